// File: rtl/lift_request_scheduler_if.sv
// rtl/lift_request_scheduler_if.sv - request/lift/door signal bundle for the lift request scheduler
interface lift_request_scheduler_if #(
  parameter int NUM_FLOORS = 15,
  parameter int FLOOR_W    = 4
);
  logic                  req_valid;
  logic [FLOOR_W-1:0]    req_floor;
  logic [FLOOR_W-1:0]    floor;
  logic                  door_open;
  logic [FLOOR_W-1:0]    target_floor;
  logic                  target_valid;
  logic                  dir_up;
  logic [NUM_FLOORS-1:0] pending;
  logic                  req_drop;
  logic                  busy;

  modport master (
    output req_valid, req_floor, floor, door_open,
    input  target_floor, target_valid, dir_up, pending, req_drop, busy
  );

  modport slave (
    input  req_valid, req_floor, floor, door_open,
    output target_floor, target_valid, dir_up, pending, req_drop, busy
  );
endinterface

// File: rtl/lift_request_scheduler.sv
// rtl/lift_request_scheduler.sv - SCAN-order floor request scheduler with door/hold stop sequencing
module lift_request_scheduler #(
  parameter int NUM_FLOORS   = 15,
  parameter int FLOOR_W      = 4,
  parameter int OPEN_TIMEOUT = 16,
  parameter int HOLD_CYCLES  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  lift_request_scheduler_if.slave bus
);
  localparam int OCW = $clog2(OPEN_TIMEOUT) + 1;
  localparam int HCW = $clog2(HOLD_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_TRAVEL, S_OPEN_WAIT, S_CLOSE_WAIT, S_HOLD
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [FLOOR_W-1:0]    target_q, target_d;
  logic                  dir_up_q, dir_up_d;
  logic                  req_drop_q, req_drop_d;
  logic [OCW-1:0]        open_cnt_q, open_cnt_d;
  logic [HCW-1:0]        hold_cnt_q, hold_cnt_d;

  logic                  arrive;
  logic                  req_accept;
  logic                  up_found, dn_found;
  logic [FLOOR_W-1:0]    up_floor, dn_floor;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pending_q  <= '0;
      target_q   <= '0;
      dir_up_q   <= 1'b1;
      req_drop_q <= 1'b0;
      open_cnt_q <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      target_q   <= target_d;
      dir_up_q   <= dir_up_d;
      req_drop_q <= req_drop_d;
      open_cnt_q <= open_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Clear on arrival is applied after the set so a same-cycle request for the target is absorbed.
  always_comb begin
    arrive     = (state_q == S_TRAVEL) && (bus.floor == target_q);
    req_drop_d = bus.req_valid &&
                 (({1'b0, bus.req_floor} >= (FLOOR_W+1)'(NUM_FLOORS)) ||
                  ((state_q == S_IDLE) && (bus.req_floor == bus.floor)));
    req_accept = bus.req_valid && !req_drop_d;
    pending_d  = pending_q;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (req_accept && (bus.req_floor == FLOOR_W'(i))) pending_d[i] = 1'b1;
      if (arrive && (target_q == FLOOR_W'(i)))          pending_d[i] = 1'b0;
    end
  end

  always_comb begin
    up_found = 1'b0;
    up_floor = '0;
    dn_found = 1'b0;
    dn_floor = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending_q[i] && (FLOOR_W'(i) > bus.floor)) begin
        up_found = 1'b1;
        up_floor = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_q[i] && (FLOOR_W'(i) < bus.floor)) begin
        dn_found = 1'b1;
        dn_floor = FLOOR_W'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    dir_up_d   = dir_up_q;
    open_cnt_d = open_cnt_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pending_q != '0) begin
          state_d = S_TRAVEL;
          // Only a request for the current floor left: serve it in place.
          target_d = bus.floor;
          if (dir_up_q) begin
            if (up_found) target_d = up_floor;
            else if (dn_found) begin
              target_d = dn_floor;
              dir_up_d = 1'b0;
            end
          end else begin
            if (dn_found) target_d = dn_floor;
            else if (up_found) begin
              target_d = up_floor;
              dir_up_d = 1'b1;
            end
          end
        end
      end
      S_TRAVEL: begin
        if (arrive) begin
          state_d    = S_OPEN_WAIT;
          open_cnt_d = '0;
        end
      end
      S_OPEN_WAIT: begin
        if (bus.door_open) begin
          state_d = S_CLOSE_WAIT;
        end else if (open_cnt_q == OCW'(OPEN_TIMEOUT - 1)) begin
          state_d    = S_HOLD;
          hold_cnt_d = '0;
        end else begin
          open_cnt_d = open_cnt_q + 1'b1;
        end
      end
      S_CLOSE_WAIT: begin
        if (!bus.door_open) begin
          state_d    = S_HOLD;
          hold_cnt_d = '0;
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == HCW'(HOLD_CYCLES - 1)) state_d = S_IDLE;
        else hold_cnt_d = hold_cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy         = (state_q != S_IDLE);
    bus.target_valid = (state_q == S_TRAVEL);
    bus.target_floor = target_q;
    bus.dir_up       = dir_up_q;
    bus.pending      = pending_q;
    bus.req_drop     = req_drop_q;
  end
endmodule

// File: tb/tb_lift_request_scheduler.sv
// tb/tb_lift_request_scheduler.sv - directed self-checking bench for lift_request_scheduler
module tb_lift_request_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  lift_request_scheduler_if #(.NUM_FLOORS(15), .FLOOR_W(4)) bus ();

  lift_request_scheduler #(
    .NUM_FLOORS(15), .FLOOR_W(4), .OPEN_TIMEOUT(16), .HOLD_CYCLES(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [3:0] f);
    bus.req_valid = 1'b1;
    bus.req_floor = f;
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Call the cycle after arrival; returns with the scheduler back in IDLE.
  task automatic serve_door();
    bus.door_open = 1'b1;
    tick();
    bus.door_open = 1'b0;
    repeat (5) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_floor = '0;
    bus.floor     = '0;
    bus.door_open = 1'b0;

    // Reset
    repeat (3) tick();
    chk("rst_target_floor", 32'(bus.target_floor), 32'd0);
    chk("rst_target_valid", 32'(bus.target_valid), 32'd0);
    chk("rst_dir_up",       32'(bus.dir_up),       32'd1);
    chk("rst_pending",      32'(bus.pending),      32'd0);
    chk("rst_req_drop",     32'(bus.req_drop),     32'd0);
    chk("rst_busy",         32'(bus.busy),         32'd0);
    rst = 1'b0;

    // Single request from floor 0 to 5
    req(4'd5);
    chk("t2_pending_n1", 32'(bus.pending),      32'h0020);
    chk("t2_valid_n1",   32'(bus.target_valid), 32'd0);
    tick();
    chk("t2_target_n2",  32'(bus.target_floor), 32'd5);
    chk("t2_valid_n2",   32'(bus.target_valid), 32'd1);
    chk("t2_busy_n2",    32'(bus.busy),         32'd1);
    bus.floor = 4'd5;
    tick();
    chk("t2_pending_arr", 32'(bus.pending),      32'd0);
    chk("t2_valid_arr",   32'(bus.target_valid), 32'd0);
    chk("t2_target_keep", 32'(bus.target_floor), 32'd5);
    bus.door_open = 1'b1;
    repeat (10) tick();
    chk("t2_busy_door", 32'(bus.busy), 32'd1);
    bus.door_open = 1'b0;
    tick();
    // Load the SCAN set during HOLD so all three are pending at once.
    bus.floor = 4'd6;
    req(4'd9);
    req(4'd12);
    req(4'd2);
    chk("t2_busy_hold",   32'(bus.busy),    32'd1);
    chk("t3_pending_set", 32'(bus.pending), 32'h1204);
    tick();
    chk("t2_busy_idle",   32'(bus.busy),    32'd0);

    // SCAN order 9, 12, then reverse to 2
    tick();
    chk("t3_target_1", 32'(bus.target_floor), 32'd9);
    chk("t3_dir_1",    32'(bus.dir_up),       32'd1);
    bus.floor = 4'd9;
    tick();
    chk("t3_pending_1", 32'(bus.pending), 32'h1004);
    serve_door();
    chk("t3_idle_1", 32'(bus.busy), 32'd0);
    tick();
    chk("t3_target_2", 32'(bus.target_floor), 32'd12);
    chk("t3_dir_2",    32'(bus.dir_up),       32'd1);
    bus.floor = 4'd12;
    tick();
    chk("t3_pending_2", 32'(bus.pending), 32'h0004);
    serve_door();
    tick();
    chk("t3_target_3", 32'(bus.target_floor), 32'd2);
    chk("t3_dir_3",    32'(bus.dir_up),       32'd0);
    chk("t3_valid_3",  32'(bus.target_valid), 32'd1);
    bus.floor = 4'd2;
    tick();
    chk("t3_pending_3", 32'(bus.pending), 32'd0);
    serve_door();

    // Drops
    req(4'd15);
    chk("t4_drop_oor",    32'(bus.req_drop), 32'd1);
    chk("t4_pending_oor", 32'(bus.pending),  32'd0);
    tick();
    chk("t4_drop_pulse",  32'(bus.req_drop), 32'd0);
    bus.floor = 4'd3;
    req(4'd3);
    chk("t4_drop_here",    32'(bus.req_drop), 32'd1);
    chk("t4_pending_here", 32'(bus.pending),  32'd0);
    tick();
    chk("t4_no_dispatch",  32'(bus.busy),     32'd0);

    // Arrival collision at floor 7
    req(4'd7);
    tick();
    chk("t5_target", 32'(bus.target_floor), 32'd7);
    chk("t5_dir",    32'(bus.dir_up),       32'd1);
    bus.floor     = 4'd7;
    bus.req_valid = 1'b1;
    bus.req_floor = 4'd7;
    tick();
    bus.req_valid = 1'b0;
    chk("t5_pending_clr", 32'(bus.pending),  32'd0);
    chk("t5_no_drop",     32'(bus.req_drop), 32'd0);
    serve_door();
    chk("t5_pending_end", 32'(bus.pending), 32'd0);
    tick();
    chk("t5_no_redispatch", 32'(bus.target_valid), 32'd0);

    // Door open timeout
    req(4'd10);
    tick();
    chk("t6_target", 32'(bus.target_floor), 32'd10);
    bus.floor = 4'd10;
    tick();
    repeat (19) tick();
    chk("t6_busy_hold",    32'(bus.busy), 32'd1);
    tick();
    chk("t6_busy_timeout", 32'(bus.busy), 32'd0);

    // Reset during TRAVEL
    req(4'd4);
    tick();
    chk("t6_target_4", 32'(bus.target_floor), 32'd4);
    chk("t6_dir_4",    32'(bus.dir_up),       32'd0);
    req(4'd12);
    chk("t6_pending_mid", 32'(bus.pending), 32'h1010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_pending", 32'(bus.pending),      32'd0);
    chk("t6_rst_valid",   32'(bus.target_valid), 32'd0);
    chk("t6_rst_busy",    32'(bus.busy),         32'd0);
    chk("t6_rst_dir",     32'(bus.dir_up),       32'd1);
    tick();
    chk("t6_rst_idle",    32'(bus.busy),         32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
